// File: rtl/multi_debouncer.sv
// Per-channel debouncer: an output bit follows its input only after STABLE_CYCLES
// consecutive differing samples. Define MULTI_DEBOUNCER_SYNC_EN to add a 2-flop synchroniser.
module multi_debouncer #(
   parameter int                  CHANNELS      = 4,
   parameter int                  STABLE_CYCLES = 1000000,
   parameter logic [CHANNELS-1:0] INIT_VALUE    = '0
) (
   input  logic                clock_50,
   input  logic                reset_key,
   input  logic [CHANNELS-1:0] noisy,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic [CHANNELS-1:0] sample;

`ifdef MULTI_DEBOUNCER_SYNC_EN
   logic [CHANNELS-1:0] sync1_q, sync2_q;

   always_ff @(posedge clock_50) begin
      if (reset_key) begin
         sync1_q <= INIT_VALUE;
         sync2_q <= INIT_VALUE;
      end else begin
         sync1_q <= noisy;
         sync2_q <= sync1_q;
      end
   end

   assign sample = sync2_q;
`else
   assign sample = noisy;
`endif

   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];
   logic [CHANNELS-1:0] deb_q, deb_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic                any_q, any_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      deb_d  = deb_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         if (sample[i] != deb_q[i]) begin
            if (cnt_q[i] == LAST) begin
               deb_d[i]  = sample[i];
               rise_d[i] = sample[i];
               fall_d[i] = ~sample[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      any_d = |(rise_d | fall_d);
   end

   // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clock_50) begin
      if (reset_key) begin
         deb_q  <= INIT_VALUE;
         rise_q <= '0;
         fall_q <= '0;
         any_q  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end else begin
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= any_d;
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign debounced  = deb_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign any_change = any_q;

endmodule
